uart_word_sender: RTL and testbench



---
 rtl/uart_word_sender.sv | 138 +++++++++++++
 tb/tb_uart_word_sender.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_sender.sv
// Two-requester round-robin arbiter that serializes the granted word MSB-first
// into a byte-wide UART transmitter using its start/ready handshake.
module uart_word_sender #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_word,
    output logic             req0_ack,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_word,
    output logic             req1_ack,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    input  logic             tx_ready,
    output logic             busy,
    output logic             done,
    output logic             done_src
);
    localparam int NBYTES = WIDTH / 8;
    localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] LAST_BYTE = CW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_grant_q, last_grant_d;
    logic             tx_start_q, tx_start_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             done_q, done_d;
    logic             done_src_q, done_src_d;
    logic             grant0, grant1, last_byte;

    // On a tie the requester that was not served last wins.
    assign grant0    = req0_valid && (!req1_valid || last_grant_q);
    assign grant1    = req1_valid && (!req0_valid || !last_grant_q);
    assign last_byte = (cnt_q == LAST_BYTE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (req0_valid || req1_valid) state_d = SEND;
            SEND:      if (tx_ready)                 state_d = WAIT_ACK;
            WAIT_ACK:  if (!tx_ready)                state_d = WAIT_DONE;
            WAIT_DONE: if (tx_ready)                 state_d = last_byte ? IDLE : SEND;
            default:                                 state_d = IDLE;
        endcase
    end

    always_comb begin
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        tx_start_d   = 1'b0;
        tx_data_d    = tx_data_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        done_d       = 1'b0;
        done_src_d   = done_src_q;
        case (state_q)
            IDLE: begin
                if (grant0) begin
                    shift_d      = req0_word;
                    cnt_d        = '0;
                    ack0_d       = 1'b1;
                    last_grant_d = 1'b0;
                end else if (grant1) begin
                    shift_d      = req1_word;
                    cnt_d        = '0;
                    ack1_d       = 1'b1;
                    last_grant_d = 1'b1;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = shift_q[WIDTH-1 -: 8];
                end
            end
            WAIT_DONE: begin
                if (tx_ready) begin
                    if (last_byte) begin
                        done_d     = 1'b1;
                        done_src_d = last_grant_q;
                    end else begin
                        shift_d = shift_q << 8;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q      <= '0;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            done_q       <= 1'b0;
            done_src_q   <= 1'b0;
        end else begin
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            done_q       <= done_d;
            done_src_q   <= done_src_d;
        end
    end

    assign req0_ack = ack0_q;
    assign req1_ack = ack1_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign done     = done_q;
    assign done_src = done_src_q;
    // The done cycle is already IDLE but still counts as part of the word.
    assign busy     = (state_q != IDLE) || done_q;

endmodule

// File: tb/tb_uart_word_sender.sv
// Randomized self-checking bench: transmitter model, requester drivers and an
// order/content reference model for uart_word_sender (32-bit and 8-bit).
module tb_uart_word_sender;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [31:0] req0_word = '0, req1_word = '0;
    logic        req0_ack, req1_ack, tx_start, busy, done, done_src;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b1;

    logic        r8_v0 = 1'b0, r8_v1 = 1'b0;
    logic [7:0]  r8_w0 = '0, r8_w1 = '0;
    logic        a8_0, a8_1, s8, busy8, done8, src8;
    logic [7:0]  d8;
    logic        r8_ready = 1'b1;

    int n_tests = 0, n_fail = 0;

    uart_word_sender #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_word(req0_word), .req0_ack(req0_ack),
        .req1_valid(req1_valid), .req1_word(req1_word), .req1_ack(req1_ack),
        .tx_start(tx_start), .tx_data(tx_data), .tx_ready(tx_ready),
        .busy(busy), .done(done), .done_src(done_src));

    uart_word_sender #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .req0_valid(r8_v0), .req0_word(r8_w0), .req0_ack(a8_0),
        .req1_valid(r8_v1), .req1_word(r8_w1), .req1_ack(a8_1),
        .tx_start(s8), .tx_data(d8), .tx_ready(r8_ready),
        .busy(busy8), .done(done8), .done_src(src8));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc++;

    // transmitter model
    int xm_state = 0, xm_cnt = 0, ack_dly = 1, busy_len = 3;
    bit force_low = 0;
    always @(negedge clk) begin
        if (rst) xm_state = 0;
        else case (xm_state)
            0: if (tx_start) begin xm_cnt = ack_dly; xm_state = 1; end
            1: begin xm_cnt--; if (xm_cnt <= 0) begin xm_cnt = busy_len; xm_state = 2; end end
            default: begin xm_cnt--; if (xm_cnt <= 0) xm_state = 0; end
        endcase
        tx_ready = !force_low && (xm_state != 2);
    end

    // requester drivers
    logic [31:0] q0[$], q1[$];
    int v0_cyc = 0, ack0_cyc = 0;
    always @(negedge clk) begin
        if (rst) begin
            req0_valid = 0; req1_valid = 0; q0.delete(); q1.delete();
        end else begin
            if (req0_ack) begin
                check("ack0_valid", req0_valid, 1);
                ack0_cyc = cyc;
                void'(q0.pop_front());
                req0_valid = 0;
            end else if (!req0_valid && q0.size() > 0) begin
                req0_valid = 1; req0_word = q0[0]; v0_cyc = cyc;
            end
            if (req1_ack) begin
                check("ack1_valid", req1_valid, 1);
                void'(q1.pop_front());
                req1_valid = 0;
            end else if (!req1_valid && q1.size() > 0) begin
                req1_valid = 1; req1_word = q1[0];
            end
        end
    end

    // output monitor / scoreboard
    logic [31:0] exp_word[$];
    logic        exp_src[$];
    logic [31:0] cur = '0;
    logic [7:0]  first_byte = '0;
    int nbytes = 0, starts = 0, dones = 0, start_cyc = 0;
    bit prev_start = 0;
    always @(negedge clk) begin
        if (rst) begin
            nbytes = 0; prev_start = 0;
        end else begin
            if (tx_start) begin
                check("start_width", prev_start, 0);
                check("start_while_low", force_low, 0);
                cur = {cur[23:0], tx_data};
                nbytes++; starts++;
                if (nbytes == 1) begin first_byte = tx_data; start_cyc = cyc; end
            end
            prev_start = tx_start;
            if (done) begin
                check("done_bytes", nbytes, 4);
                check("busy_in_done", busy, 1);
                if (exp_word.size() == 0) check("done_unexpected", 1, 0);
                else begin
                    check("done_word", cur, exp_word.pop_front());
                    check("done_src", done_src, exp_src.pop_front());
                end
                dones++; nbytes = 0;
            end
        end
    end

    // reference model: alternating grants while both have words, else drain one
    logic        m_last = 1;
    logic [31:0] s0[$], s1[$];
    task automatic plan_and_go();
        logic [31:0] a[$], b[$];
        a = s0; b = s1;
        while (a.size() > 0 || b.size() > 0) begin
            logic pick;
            if (a.size() > 0 && b.size() > 0) pick = !m_last;
            else pick = (a.size() == 0);
            if (pick) exp_word.push_back(b.pop_front());
            else      exp_word.push_back(a.pop_front());
            exp_src.push_back(pick);
            m_last = pick;
        end
        q0 = s0; q1 = s1;
    endtask

    task automatic wait_dones(input int target, input int budget);
        for (int i = 0; i < budget && dones < target; i++) @(negedge clk);
        check("dones_reached", dones, target);
    endtask

    task automatic do_reset();
        @(negedge clk); #1 rst = 1;
        repeat (2) @(negedge clk);
        #1 rst = 0; m_last = 1;
    endtask

    int base, d0, s8_cnt = 0;
    always @(negedge clk) if (s8) s8_cnt++;

    initial begin
        #2;
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_acks", {req0_ack, req1_ack}, 0);
        check("rst_done", {done, done_src}, 0);
        check("rst_busy", busy, 0);
        @(negedge clk); #1 rst = 0;

        // single request
        @(negedge clk); #1;
        s0 = '{32'hDEADBEEF}; s1 = '{}; base = starts;
        plan_and_go();
        wait_dones(1, 200);
        check("ack_latency", ack0_cyc - v0_cyc, 1);
        check("start_latency", start_cyc - v0_cyc, 2);
        check("single_starts", starts - base, 4);
        @(negedge clk);
        check("idle_busy", busy, 0);

        // tie after reset, then continuous round-robin
        do_reset();
        s0 = '{32'h11223344}; s1 = '{32'hA0B0C0D0};
        plan_and_go();
        wait_dones(dones + 2, 400);
        @(negedge clk); #1;
        s0 = '{32'h00000001, 32'h00000002}; s1 = '{32'h10000001, 32'h10000002};
        plan_and_go();
        wait_dones(dones + 4, 800);

        // back-pressure with a stretched accept delay
        @(negedge clk); #1 force_low = 1; ack_dly = 5;
        s0 = '{32'h55AA33CC}; s1 = '{}; base = starts;
        plan_and_go();
        repeat (50) @(negedge clk);
        check("bp_no_start", starts - base, 0);
        check("bp_busy", busy, 1);
        #1 force_low = 0;
        wait_dones(dones + 1, 400);
        check("bp_starts", starts - base, 4);
        ack_dly = 1;

        // reset mid-word
        @(negedge clk); #1;
        q0 = '{32'hCAFEF00D}; base = starts; d0 = dones;
        for (int i = 0; i < 200 && starts < base + 2; i++) @(negedge clk);
        check("mid_two_bytes", starts - base, 2);
        #2 rst = 1;
        #1;
        check("async_tx_start", tx_start, 0);
        check("async_tx_data", tx_data, 0);
        check("async_acks", {req0_ack, req1_ack}, 0);
        check("async_done", {done, done_src}, 0);
        check("async_busy", busy, 0);
        repeat (2) @(negedge clk);
        #1 rst = 0; m_last = 1;
        repeat (3) @(negedge clk);
        check("no_done_after_rst", dones, d0);
        #1;
        s0 = '{32'h01020304}; s1 = '{};
        plan_and_go();
        wait_dones(dones + 1, 200);
        check("restart_first_byte", first_byte, 8'h01);

        // randomized traffic
        for (int r = 0; r < 4; r++) begin
            @(negedge clk); #1;
            ack_dly = $urandom_range(1, 4);
            busy_len = $urandom_range(2, 6);
            s0 = '{}; s1 = '{};
            for (int k = $urandom_range(0, 3); k > 0; k--) s0.push_back($urandom);
            for (int k = $urandom_range(1, 3); k > 0; k--) s1.push_back($urandom);
            d0 = dones + s0.size() + s1.size();
            plan_and_go();
            wait_dones(d0, 3000);
        end
        check("exp_drained", exp_word.size(), 0);

        // 8-bit instance
        @(negedge clk); #1 r8_v1 = 1; r8_w1 = 8'h5A;
        @(negedge clk);
        for (int i = 0; i < 10 && !a8_1; i++) @(negedge clk);
        check("w8_ack", a8_1, 1);
        r8_v1 = 0;
        for (int i = 0; i < 10 && !s8; i++) @(negedge clk);
        check("w8_start", s8, 1);
        check("w8_data", d8, 8'h5A);
        @(negedge clk);
        check("w8_start_width", s8, 0);
        r8_ready = 0;
        repeat (3) @(negedge clk);
        r8_ready = 1;
        for (int i = 0; i < 10 && !done8; i++) @(negedge clk);
        check("w8_done", done8, 1);
        check("w8_src", src8, 1);
        repeat (5) @(negedge clk);
        check("w8_starts", s8_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got time limit expected completion");
        $fatal(1, "timeout");
    end
endmodule
